// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks with registered inter-chunk carries.
// Optional OVERFLOW_FLAG_EN adds a signed-overflow output aligned with sum.
module pipelined_rca_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = WIDTH / STAGES;

    // Whole pipe shifts together; it only freezes when the output is occupied and not taken.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be summed at this stage, and sum bits produced so far.
        localparam int unsigned OW = WIDTH - k * CW;
        localparam int unsigned SW = (k + 1) * CW;

        logic [OW-1:0] a_in;
        logic [OW-1:0] b_in;
        logic          c_in;
        logic          v_in;
        logic [CW:0]   chunk;
        logic [SW-1:0] sum_d;

        logic          v_q;
        logic          c_q;
        logic [SW-1:0] sum_q;

        if (k == 0) begin : g_first
            assign a_in  = a;
            assign b_in  = sub ? ~b : b;
            assign c_in  = sub | cin;
            assign v_in  = in_valid;
            assign sum_d = chunk[CW-1:0];
        end else begin : g_next
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign c_in  = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].v_q;
            assign sum_d = {chunk[CW-1:0], g_stage[k-1].sum_q};
        end

        assign chunk = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

        // Data only loads on a valid op so bubbles leave the previous result in place.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q   <= chunk[CW];
                    sum_q <= sum_d;
                end
            end
        end

        // Skew: carry the not-yet-summed upper operand chunks forward.
        if (k < STAGES - 1) begin : g_fwd
            logic [OW-CW-1:0] a_q;
            logic [OW-CW-1:0] b_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && v_in) begin
                    a_q <= a_in[OW-1:CW];
                    b_q <= b_in[OW-1:CW];
                end
            end
        end

`ifdef OVERFLOW_FLAG_EN
        // Carry into MSB is recovered from the MSB sum bit, then xored with carry out.
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_in) begin
                    ovf_q <= a_in[CW-1] ^ b_in[CW-1] ^ chunk[CW-1] ^ chunk[CW];
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].c_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Bench for pipelined_rca_adder: 8-bit/2-stage main instance, plus 8-bit/1-stage and 16-bit/4-stage instances.
module tb_pipelined_rca_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
    } v16_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       in_ready, out_valid, cout;
    logic [7:0] sum;

    logic       in_ready1, out_valid1, cout1;
    logic [7:0] sum1;

    logic        in_valid2 = 1'b0;
    logic [15:0] a2 = '0;
    logic [15:0] b2 = '0;
    logic        cin2 = 1'b0;
    logic        sub2 = 1'b0;
    logic        in_ready2, out_valid2, cout2;
    logic [15:0] sum2;

`ifdef OVERFLOW_FLAG_EN
    logic ovf, ovf1, ovf2;
`endif

    pipelined_rca_adder #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef OVERFLOW_FLAG_EN
        , .ovf(ovf)
`endif
    );

    pipelined_rca_adder #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(1'b1), .sum(sum1), .cout(cout1)
`ifdef OVERFLOW_FLAG_EN
        , .ovf(ovf1)
`endif
    );

    pipelined_rca_adder #(.WIDTH(16), .STAGES(4)) u_dut_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .out_valid(out_valid2), .out_ready(1'b1), .sum(sum2), .cout(cout2)
`ifdef OVERFLOW_FLAG_EN
        , .ovf(ovf2)
`endif
    );

    int   nvec = 0;
    int   nerr = 0;
    bit   mon_en = 1'b0;
    vec_t cur;
    vec_t expq[$];
    vec_t vecs[15];
    v16_t v16[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Output-side scoreboard for the 2-stage instance; inputs are recorded on transfer.
    always @(negedge clk) begin
        vec_t e;
        if (mon_en && rst) begin
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL stream_spurious: sum=%0d cout=%0d with nothing outstanding", sum, cout);
                end else begin
                    e = expq.pop_front();
                    chk("stream_sum", 32'(sum), 32'(e.sum));
                    chk("stream_cout", 32'(cout), 32'(e.cout));
`ifdef OVERFLOW_FLAG_EN
                    chk("stream_ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
            if (in_valid && in_ready) expq.push_back(cur);
        end
    end

    // Offer one op until the 2-stage instance takes it; the 1-stage instance must show it right after.
    task automatic send(input vec_t v);
        int n;
        bit acc;
        cur = v; a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            chk("send_timeout", 32'(acc), 32'd1);
        end else begin
            chk("s1_valid", 32'(out_valid1), 32'd1);
            chk("s1_sum", 32'(sum1), 32'(v.sum));
            chk("s1_cout", 32'(cout1), 32'(v.cout));
`ifdef OVERFLOW_FLAG_EN
            chk("s1_ovf", 32'(ovf1), 32'(v.ovf));
`endif
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'd32,  8'd32,  1'b0, 1'b0, 8'd64,  1'b0, 1'b0};
        vecs[1]  = '{8'd200, 8'd200, 1'b0, 1'b0, 8'd144, 1'b1, 1'b0};
        vecs[2]  = '{8'd255, 8'd0,   1'b1, 1'b0, 8'd0,   1'b1, 1'b0};
        vecs[3]  = '{8'd15,  8'd1,   1'b0, 1'b0, 8'd16,  1'b0, 1'b0};
        vecs[4]  = '{8'd20,  8'd75,  1'b0, 1'b1, 8'd201, 1'b0, 1'b0};
        vecs[5]  = '{8'd75,  8'd20,  1'b0, 1'b1, 8'd55,  1'b1, 1'b0};
        vecs[6]  = '{8'd0,   8'd0,   1'b0, 1'b1, 8'd0,   1'b1, 1'b0};
        vecs[7]  = '{8'd255, 8'd255, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0};
        vecs[8]  = '{8'd10,  8'd3,   1'b1, 1'b1, 8'd7,   1'b1, 1'b0};
        vecs[9]  = '{8'd8,   8'd8,   1'b0, 1'b0, 8'd16,  1'b0, 1'b0};
        vecs[10] = '{8'd128, 8'd128, 1'b0, 1'b0, 8'd0,   1'b1, 1'b1};
        vecs[11] = '{8'd15,  8'd240, 1'b1, 1'b0, 8'd0,   1'b1, 1'b0};
        vecs[12] = '{8'd100, 8'd100, 1'b0, 1'b0, 8'd200, 1'b0, 1'b1};
        vecs[13] = '{8'd128, 8'd1,   1'b0, 1'b1, 8'd127, 1'b1, 1'b1};
        vecs[14] = '{8'd5,   8'd3,   1'b0, 1'b0, 8'd8,   1'b0, 1'b0};

        v16[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        v16[1] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0};
        v16[2] = '{16'h1234, 16'h1235, 1'b0, 1'b1, 16'hFFFF, 1'b0};
        v16[3] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1};
        v16[4] = '{16'h0100, 16'h0001, 1'b1, 1'b1, 16'h00FF, 1'b1};
        v16[5] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0};

        // Reset state
        rst = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        out_ready = 1'b1;

        // Exact two-cycle latency
        send(vecs[0]);
        @(negedge clk);
        chk("lat_early_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_sum", 32'(sum), 32'd64);
        @(posedge clk);
        #1;

        // Table, back-to-back
        for (int i = 0; i < 15; i++) send(vecs[i]);
        drain();

        // Backpressure: two ops fill the pipe, third waits
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        cur = vecs[3]; a = vecs[3].a; b = vecs[3].b; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(sum), 32'd64);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(vecs[3]);
        drain();

        // Reset with two ops in flight
        mon_en = 1'b0;
        send(vecs[5]);
        send(vecs[6]);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_s1_valid", 32'(out_valid1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expq.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;

        // 16-bit, 4 stages: one op per cycle, result exactly 4 cycles later
        for (int c = 0; c < 10; c++) begin
            if (c < 6) begin
                a2 = v16[c].a; b2 = v16[c].b; cin2 = v16[c].cin; sub2 = v16[c].sub; in_valid2 = 1'b1;
            end else begin
                in_valid2 = 1'b0;
            end
            @(negedge clk);
            if (c == 3) chk("w16_lat_early", 32'(out_valid2), 32'd0);
            if (c >= 4) begin
                chk("w16_valid", 32'(out_valid2), 32'd1);
                chk("w16_sum", 32'(sum2), 32'(v16[c-4].sum));
                chk("w16_cout", 32'(cout2), 32'(v16[c-4].cout));
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("w16_drained", 32'(out_valid2), 32'd0);

        chk("final_outstanding", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
